// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and one carry flop, LSB first.
// It takes parallel operands on start and returns a parallel sum and carry-out after WIDTH edges.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_cf;
  logic [RW-1:0]    r_res;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic [RW-1:0]    w_res_keep;

  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_cf;
  assign w_co   = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_cf) | (r_b_sh[0] & r_cf);
  assign w_last = (r_count == CW'(WIDTH - 1));

  // The result register keeps only the WIDTH-1 bits already produced.
  // The current slice bit is merged in on the fly, so the final edge can publish the whole word.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_nxt  = w_s;
      assign w_res_keep = w_s;
    end else begin : g_wn
      assign w_res_nxt  = {w_s, r_res};
      assign w_res_keep = w_res_nxt[WIDTH-1:1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cf    <= 1'b0;
      r_res   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_cf    <= c;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_cf    <= w_co;
          r_res   <= w_res_keep;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_sum   <= w_res_nxt;
            r_carry <= w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance and a 1-bit instance share clock and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, c8, busy8, done8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       start1, c1, busy1, done1, carry1;
  logic [0:0] a1, b1, sum1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c(c8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    logic [7:0] prev_s;
    logic       prev_c;
    int         lat;
    prev_s = sum8;
    prev_c = carry8;
    lat    = 0;
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, " busy_set"}, 32'(busy8), 32'd1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8) begin
        lat = i;
        break;
      end
      chk({tag, " busy"}, 32'(busy8), 32'd1);
      chk({tag, " hold"}, {23'd0, prev_c, prev_s}, {23'd0, carry8, sum8});
    end
    chk({tag, " latency"}, 32'(lat), 32'd8);
    chk({tag, " sum"}, 32'(sum8), 32'(es));
    chk({tag, " carry"}, 32'(carry8), 32'(ec));
    chk({tag, " busy_clr"}, 32'(busy8), 32'd0);
    tick();
    chk({tag, " done_clr"}, 32'(done8), 32'd0);
  endtask

  task automatic add1(input int idx, input logic a, input logic b, input logic c,
                      input logic es, input logic ec);
    string tag;
    tag = $sformatf("w1_%0d", idx);
    a1 = a; b1 = b; c1 = c; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({tag, " busy"}, 32'(busy1), 32'd1);
    tick();
    chk({tag, " done"}, 32'(done1), 32'd1);
    chk({tag, " sum"}, 32'(sum1), 32'(es));
    chk({tag, " carry"}, 32'(carry1), 32'(ec));
    chk({tag, " busy_clr"}, 32'(busy1), 32'd0);
    tick();
    chk({tag, " done_clr"}, 32'(done1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tt_s;
    logic [7:0] tt_c;
    logic [2:0] v;
    logic [7:0] cap_s;
    logic       cap_c;
    int         ndone;
    int         gap;
    int         lat;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    tick();
    tick();
    chk("rst busy8", 32'(busy8), 32'd0);
    chk("rst done8", 32'(done8), 32'd0);
    chk("rst sum8", 32'(sum8), 32'd0);
    chk("rst carry8", 32'(carry8), 32'd0);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst out1", {30'd0, carry1, sum1}, 32'd0);
    rst_n = 1'b1;
    tick();

    add8("basic", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
    add8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8("5a_a5", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
    add8("ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      add1(i, v[2], v[1], v[0], tt_s[i], tt_c[i]);
    end

    // Ignored start plus operand churn while the addition is in flight
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; cap_s = '0; cap_c = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      tick();
      if (done8) begin
        ndone++;
        cap_s = sum8;
        cap_c = carry8;
      end else if (i < 8) begin
        chk("ign hold", {23'd0, carry8, sum8}, {23'd0, 1'b1, 8'hFF});
      end
    end
    start8 = 1'b0;
    chk("ign ndone", 32'(ndone), 32'd1);
    chk("ign sum", 32'(cap_s), 32'h30);
    chk("ign carry", 32'(cap_c), 32'd0);

    // Back-to-back: start held through DONE is dropped there and accepted in IDLE
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk("b2b lat1", 32'(lat), 32'd8);
    chk("b2b sum1", 32'(sum8), 32'h03);
    a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) chk("b2b ignored", 32'(busy8), 32'd0);
      if (i == 2) begin
        chk("b2b accepted", 32'(busy8), 32'd1);
        start8 = 1'b0;
      end
      if (done8) begin
        gap = i;
        break;
      end
    end
    start8 = 1'b0;
    chk("b2b gap", 32'(gap), 32'd10);
    chk("b2b sum2", 32'(sum8), 32'h10);
    chk("b2b carry2", 32'(carry8), 32'd0);
    tick();

    // Reset at the 4th ADD edge
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort busy", 32'(busy8), 32'd0);
    chk("abort done", 32'(done8), 32'd0);
    chk("abort sum", 32'(sum8), 32'd0);
    chk("abort carry", 32'(carry8), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    chk("abort nodone", 32'(ndone), 32'd0);
    add8("fresh", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
